register_file: RTL and testbench
================================

Name: register_file

Overview:
- Architectural register file with a rename-tag table.
- Sits between decoder (ID), reorder buffer (ROB) and reservation stations.
- Consumes ROB commit writes and ROB mispredict flush. Records new rename tags issued by ID.
- Resolves ID's source operands into (tag, value) pairs. For a renamed register it queries the ROB through the RF_id request port.

Parameters:
- REGNUM, 32, number of architectural registers; x0 hard-wired to zero.
- ROBWD, 4, ROB index width; tags are 32-bit ROB ids whose low ROBWD bits index the ROB.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- rdy  in  1  global enable; low = hold all state.
- jump_wrong_flag  in  1  ROB mispredict pulse; flush all tags.
- ID_inst_flag  in  1  ID issues an instruction this cycle.
- ID_inst_rd  in  5  destination register of issued instruction.
- ID_inst_rob_id  in  32  ROB id assigned to issued instruction.
- ID_rs1  in  5  source register 1 index.
- ID_rs2  in  5  source register 2 index.
- ID_qj  out  32  rs1 pending tag; 0 = value valid.
- ID_vj  out  32  rs1 value, valid when ID_qj==0.
- ID_qk  out  32  rs2 pending tag; 0 = value valid.
- ID_vk  out  32  rs2 value, valid when ID_qk==0.
- ROB_cmt_rf_flag  in  1  ROB commit write valid.
- ROB_cmt_rf_rd  in  5  commit destination register.
- ROB_cmt_rf_rob_id  in  32  ROB id of committing entry.
- ROB_cmt_rf_val  in  32  commit value.
- RF_id1  out  32  ROB id queried for rs1 (0 when unused).
- RF_id2  out  32  ROB id queried for rs2 (0 when unused).
- RF_id1_ready  in  1  ROB entry RF_id1 has its result.
- RF_id2_ready  in  1  ROB entry RF_id2 has its result.
- RF_id1_val  in  32  ROB value for RF_id1.
- RF_id2_val  in  32  ROB value for RF_id2.

Behaviour:
- State: val[0..31] (32b), tag[0..31] (32b, 0 = not renamed). ROB ids are never 0, because the ROB head starts at 1.
- Reset (rst==0 at posedge): all val and tag cleared to 0. Outputs are combinational; after reset ID_qj=ID_qk=0, ID_vj=ID_vk=0, RF_id1=RF_id2=0.
- rdy==0: no state change. Combinational outputs keep tracking inputs.

Operand read, combinational, same cycle, evaluated per source s (rs1 via port 1, rs2 via port 2):
- s==0: q=0, v=0.
- tag[s]==0: q=0, v=val[s].
- Commit-forwarding: ROB_cmt_rf_flag && ROB_cmt_rf_rd==s && ROB_cmt_rf_rob_id==tag[s] gives q=0, v=ROB_cmt_rf_val.
- Otherwise RF_idN=tag[s].
  - If RF_idN_ready: q=0, v=RF_idN_val.
  - Else: q=tag[s], v=0.
- Reads never see the same-cycle issue of ID_inst_rd. An instruction's sources use the mapping before its own rename.

Sequential update (posedge, rst==1, rdy==1), in priority order:
- 1. Commit: if ROB_cmt_rf_flag && ROB_cmt_rf_rd!=0:
  - write val[rd] = ROB_cmt_rf_val;
  - if tag[rd]==ROB_cmt_rf_rob_id, clear tag[rd] to 0.
  - A stale commit (tag mismatch) still writes the value but keeps the newer tag.
- 2. Flush: if jump_wrong_flag, every tag is set to 0.
  - The commit in step 1 in the same cycle is still applied; it is the mispredicted JAL/JALR's link write.
  - ID_inst_flag in the same cycle is ignored.
- 3. Issue: if !jump_wrong_flag && ID_inst_flag && ID_inst_rd!=0, tag[rd] = ID_inst_rob_id.
  - Issue overrides a same-cycle tag clear from a commit to the same rd.
- Writes to x0 (commit or issue) are dropped; val[0] and tag[0] stay 0.
- No internal flow control: the block accepts one issue and one commit every cycle.

Optional Feature:
- Macro RF_DEBUG_EN.
- Defined:
  - adds ports dbg_rf_sel (in, 5) and dbg_rf_val (out, 32). dbg_rf_val = val[dbg_rf_sel], combinational.
  - adds dbg_cmt_cnt (out, 32): counts accepted commit writes with rd!=0, including those in a flush cycle. Reset 0, holds when rdy==0.
- Undefined: these ports and the counter do not exist; functional behaviour is identical.

Test Plan:
- Reset then idle: ID_rs1=5, ID_rs2=0 -> ID_qj=0, ID_vj=0, ID_qk=0, RF_id1=0.
- Issue rd=3 rob_id=7, next cycle ID_rs1=3 with RF_id1_ready=0 -> RF_id1=7, ID_qj=7. Drive RF_id1_ready=1, RF_id1_val=0x55 -> ID_qj=0, ID_vj=0x55.
- Commit rd=3 rob_id=7 val=0x1234 with ID_rs1=3 the same cycle -> ID_qj=0, ID_vj=0x1234 (forwarded). Next cycle tag[3]=0 and val[3]=0x1234.
- Stale commit and override: issue rd=4 id=9, then issue rd=4 id=12, then commit rd=4 id=9 val=0xAA -> val[4]=0xAA, ID_qj for rs1=4 stays 12. Commit rd=4 id=12 plus issue rd=4 id=15 in the same cycle -> tag[4]=15.
- Flush: tags set on x1 (id 20) and x2 (id 21). Pulse jump_wrong_flag together with commit rd=1 id=20 val=0x8 and ID_inst_flag rd=5 id=22 -> all tags 0, val[1]=0x8, x5 untagged.
- rdy=0 during issue rd=6 id=30 and commit rd=7 val=1 -> tag[6] and val[7] unchanged. Writes to x0 via commit val=0xFF -> rs1=0 reads 0.

Source files
------------

// File: rtl/register_file.sv
// Architectural register file with rename-tag table: resolves ID source operands
// into (tag, value) pairs, absorbs ROB commits and mispredict flushes.
// Optional debug read port and commit counter enabled by defining RF_DEBUG_EN.
module register_file #(
  parameter int REGNUM = 32,
  parameter int ROBWD  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_wrong_flag,
  input  logic        ID_inst_flag,
  input  logic [4:0]  ID_inst_rd,
  input  logic [31:0] ID_inst_rob_id,
  input  logic [4:0]  ID_rs1,
  input  logic [4:0]  ID_rs2,
  output logic [31:0] ID_qj,
  output logic [31:0] ID_vj,
  output logic [31:0] ID_qk,
  output logic [31:0] ID_vk,
  input  logic        ROB_cmt_rf_flag,
  input  logic [4:0]  ROB_cmt_rf_rd,
  input  logic [31:0] ROB_cmt_rf_rob_id,
  input  logic [31:0] ROB_cmt_rf_val,
  output logic [31:0] RF_id1,
  output logic [31:0] RF_id2,
  input  logic        RF_id1_ready,
  input  logic        RF_id2_ready,
  input  logic [31:0] RF_id1_val,
  input  logic [31:0] RF_id2_val
`ifdef RF_DEBUG_EN
  ,
  input  logic [4:0]  dbg_rf_sel,
  output logic [31:0] dbg_rf_val,
  output logic [31:0] dbg_cmt_cnt
`endif
);

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t q;
    word_t v;
    word_t id;
  } operand_t;

  // Tags are full 32-bit ROB ids; the index width only has to be sane.
  if (ROBWD < 1 || ROBWD > 31) begin : g_bad_robwd
    $error("register_file: ROBWD out of range");
  end

  word_t val_q [REGNUM];
  word_t tag_q [REGNUM];
  word_t val_d [REGNUM];
  word_t tag_d [REGNUM];

  operand_t op1;
  operand_t op2;

  logic cmt_valid;
  assign cmt_valid = ROB_cmt_rf_flag && (ROB_cmt_rf_rd != 5'd0);

  // A renamed source resolves from the same-cycle commit first, then from the ROB.
  function automatic operand_t resolve(
    input logic [4:0] src,
    input word_t      src_tag,
    input word_t      src_val,
    input logic       rob_ready,
    input word_t      rob_val
  );
    operand_t r;
    r = '0;
    if (src == 5'd0) begin
      r = '0;
    end else if (src_tag == '0) begin
      r.v = src_val;
    end else if (ROB_cmt_rf_flag && (ROB_cmt_rf_rd == src) &&
                 (ROB_cmt_rf_rob_id == src_tag)) begin
      r.v = ROB_cmt_rf_val;
    end else begin
      r.id = src_tag;
      if (rob_ready) begin
        r.v = rob_val;
      end else begin
        r.q = src_tag;
      end
    end
    return r;
  endfunction

  always_comb begin
    op1 = resolve(ID_rs1, tag_q[ID_rs1], val_q[ID_rs1], RF_id1_ready, RF_id1_val);
    op2 = resolve(ID_rs2, tag_q[ID_rs2], val_q[ID_rs2], RF_id2_ready, RF_id2_val);
  end

  assign ID_qj  = op1.q;
  assign ID_vj  = op1.v;
  assign RF_id1 = op1.id;
  assign ID_qk  = op2.q;
  assign ID_vk  = op2.v;
  assign RF_id2 = op2.id;

  // Commit, then flush, then issue: later steps override earlier tag writes.
  always_comb begin
    // NOTE: next-state starts as a copy of current state so no path leaves it unassigned (no latches).
    val_d = val_q;
    tag_d = tag_q;
    if (cmt_valid) begin
      val_d[ROB_cmt_rf_rd] = ROB_cmt_rf_val;
      if (tag_q[ROB_cmt_rf_rd] == ROB_cmt_rf_rob_id) begin
        tag_d[ROB_cmt_rf_rd] = '0;
      end
    end
    if (jump_wrong_flag) begin
      for (int i = 0; i < REGNUM; i++) begin
        tag_d[i] = '0;
      end
    end else if (ID_inst_flag && (ID_inst_rd != 5'd0)) begin
      tag_d[ID_inst_rd] = ID_inst_rob_id;
    end
  end

  // NOTE: both arrays are reset because architectural state must read as zero after reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst) begin
      val_q <= '{default: '0};
      tag_q <= '{default: '0};
    end else if (rdy) begin
      val_q <= val_d;
      tag_q <= tag_d;
    end
  end

`ifdef RF_DEBUG_EN
  assign dbg_rf_val = val_q[dbg_rf_sel];

  always_ff @(posedge clk) begin
    if (!rst) begin
      dbg_cmt_cnt <= '0;
    end else if (rdy && cmt_valid) begin
      dbg_cmt_cnt <= dbg_cmt_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios followed by
// randomized traffic compared against a rule-level reference model.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        jump_wrong_flag;
  logic        ID_inst_flag;
  logic [4:0]  ID_inst_rd;
  logic [31:0] ID_inst_rob_id;
  logic [4:0]  ID_rs1;
  logic [4:0]  ID_rs2;
  logic [31:0] ID_qj, ID_vj, ID_qk, ID_vk;
  logic        ROB_cmt_rf_flag;
  logic [4:0]  ROB_cmt_rf_rd;
  logic [31:0] ROB_cmt_rf_rob_id;
  logic [31:0] ROB_cmt_rf_val;
  logic [31:0] RF_id1, RF_id2;
  logic        RF_id1_ready, RF_id2_ready;
  logic [31:0] RF_id1_val, RF_id2_val;
`ifdef RF_DEBUG_EN
  logic [4:0]  dbg_rf_sel = 5'd0;
  logic [31:0] dbg_rf_val;
  logic [31:0] dbg_cmt_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state: plain arrays of register values and rename tags.
  logic [31:0] mval [32];
  logic [31:0] mtag [32];

  register_file dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .jump_wrong_flag   (jump_wrong_flag),
    .ID_inst_flag      (ID_inst_flag),
    .ID_inst_rd        (ID_inst_rd),
    .ID_inst_rob_id    (ID_inst_rob_id),
    .ID_rs1            (ID_rs1),
    .ID_rs2            (ID_rs2),
    .ID_qj             (ID_qj),
    .ID_vj             (ID_vj),
    .ID_qk             (ID_qk),
    .ID_vk             (ID_vk),
    .ROB_cmt_rf_flag   (ROB_cmt_rf_flag),
    .ROB_cmt_rf_rd     (ROB_cmt_rf_rd),
    .ROB_cmt_rf_rob_id (ROB_cmt_rf_rob_id),
    .ROB_cmt_rf_val    (ROB_cmt_rf_val),
    .RF_id1            (RF_id1),
    .RF_id2            (RF_id2),
    .RF_id1_ready      (RF_id1_ready),
    .RF_id2_ready      (RF_id2_ready),
    .RF_id1_val        (RF_id1_val),
    .RF_id2_val        (RF_id2_val)
`ifdef RF_DEBUG_EN
    ,
    .dbg_rf_sel        (dbg_rf_sel),
    .dbg_rf_val        (dbg_rf_val),
    .dbg_cmt_cnt       (dbg_cmt_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    jump_wrong_flag   = 1'b0;
    ID_inst_flag      = 1'b0;
    ID_inst_rd        = 5'd0;
    ID_inst_rob_id    = 32'd0;
    ROB_cmt_rf_flag   = 1'b0;
    ROB_cmt_rf_rd     = 5'd0;
    ROB_cmt_rf_rob_id = 32'd0;
    ROB_cmt_rf_val    = 32'd0;
    RF_id1_ready      = 1'b0;
    RF_id2_ready      = 1'b0;
    RF_id1_val        = 32'd0;
    RF_id2_val        = 32'd0;
  endtask

  // Apply the clock-edge rules to the model: commit, then flush, then issue.
  task automatic model_update();
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        mval[i] = 32'd0;
        mtag[i] = 32'd0;
      end
    end else if (rdy) begin
      if (ROB_cmt_rf_flag && ROB_cmt_rf_rd != 5'd0) begin
        mval[ROB_cmt_rf_rd] = ROB_cmt_rf_val;
        if (mtag[ROB_cmt_rf_rd] == ROB_cmt_rf_rob_id) mtag[ROB_cmt_rf_rd] = 32'd0;
      end
      if (jump_wrong_flag) begin
        for (int i = 0; i < 32; i++) mtag[i] = 32'd0;
      end else if (ID_inst_flag && ID_inst_rd != 5'd0) begin
        mtag[ID_inst_rd] = ID_inst_rob_id;
      end
    end
  endtask

  task automatic model_read(input logic [4:0] s, input logic rob_ready, input logic [31:0] rob_val,
                            output logic [31:0] q, output logic [31:0] v, output logic [31:0] id);
    q = 32'd0;
    v = 32'd0;
    id = 32'd0;
    if (s == 5'd0) begin
      v = 32'd0;
    end else if (mtag[s] == 32'd0) begin
      v = mval[s];
    end else if (ROB_cmt_rf_flag && ROB_cmt_rf_rd == s && ROB_cmt_rf_rob_id == mtag[s]) begin
      v = ROB_cmt_rf_val;
    end else begin
      id = mtag[s];
      if (rob_ready) v = rob_val;
      else q = mtag[s];
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] eq, ev, eid;

  initial begin
    idle();
    rdy = 1'b1;
    rst = 1'b0;
    ID_rs1 = 5'd0;
    ID_rs2 = 5'd0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b1;

    // Reset state, idle reads.
    ID_rs1 = 5'd5; ID_rs2 = 5'd0;
    #1;
    check("reset_qj", ID_qj, 32'd0);
    check("reset_vj", ID_vj, 32'd0);
    check("reset_qk", ID_qk, 32'd0);
    check("reset_vk", ID_vk, 32'd0);
    check("reset_rf_id1", RF_id1, 32'd0);
    check("reset_rf_id2", RF_id2, 32'd0);

    // Issue rd=3 id=7, then read through the ROB query port.
    ID_inst_flag = 1'b1; ID_inst_rd = 5'd3; ID_inst_rob_id = 32'd7;
    tick();
    idle();
    ID_rs1 = 5'd3;
    #1;
    check("renamed_rf_id1", RF_id1, 32'd7);
    check("renamed_qj", ID_qj, 32'd7);
    check("renamed_vj", ID_vj, 32'd0);
    RF_id1_ready = 1'b1; RF_id1_val = 32'h55;
    #1;
    check("rob_ready_qj", ID_qj, 32'd0);
    check("rob_ready_vj", ID_vj, 32'h55);
    RF_id1_ready = 1'b0; RF_id1_val = 32'd0;

    // Commit rd=3 id=7 with same-cycle forwarding.
    ROB_cmt_rf_flag = 1'b1; ROB_cmt_rf_rd = 5'd3; ROB_cmt_rf_rob_id = 32'd7; ROB_cmt_rf_val = 32'h1234;
    #1;
    check("fwd_qj", ID_qj, 32'd0);
    check("fwd_vj", ID_vj, 32'h1234);
    check("fwd_rf_id1", RF_id1, 32'd0);
    tick();
    idle();
    #1;
    check("post_cmt_qj", ID_qj, 32'd0);
    check("post_cmt_vj", ID_vj, 32'h1234);
    check("post_cmt_rf_id1", RF_id1, 32'd0);

    // Stale commit keeps the newer tag; commit+issue on the same rd keeps the issue.
    ID_inst_flag = 1'b1; ID_inst_rd = 5'd4; ID_inst_rob_id = 32'd9;
    tick();
    ID_inst_rob_id = 32'd12;
    tick();
    idle();
    ROB_cmt_rf_flag = 1'b1; ROB_cmt_rf_rd = 5'd4; ROB_cmt_rf_rob_id = 32'd9; ROB_cmt_rf_val = 32'hAA;
    ID_rs1 = 5'd4;
    #1;
    check("stale_no_fwd_qj", ID_qj, 32'd12);
    tick();
    idle();
    #1;
    check("stale_tag_kept_qj", ID_qj, 32'd12);
    check("stale_tag_kept_rf_id1", RF_id1, 32'd12);
    ROB_cmt_rf_flag = 1'b1; ROB_cmt_rf_rd = 5'd4; ROB_cmt_rf_rob_id = 32'd12; ROB_cmt_rf_val = 32'hBB;
    ID_inst_flag = 1'b1; ID_inst_rd = 5'd4; ID_inst_rob_id = 32'd15;
    tick();
    idle();
    #1;
    check("issue_overrides_clear_qj", ID_qj, 32'd15);

    // Flush together with a commit and an (ignored) issue.
    ID_inst_flag = 1'b1; ID_inst_rd = 5'd1; ID_inst_rob_id = 32'd20;
    tick();
    ID_inst_rd = 5'd2; ID_inst_rob_id = 32'd21;
    tick();
    idle();
    jump_wrong_flag = 1'b1;
    ROB_cmt_rf_flag = 1'b1; ROB_cmt_rf_rd = 5'd1; ROB_cmt_rf_rob_id = 32'd20; ROB_cmt_rf_val = 32'h8;
    ID_inst_flag = 1'b1; ID_inst_rd = 5'd5; ID_inst_rob_id = 32'd22;
    tick();
    idle();
    ID_rs1 = 5'd1; ID_rs2 = 5'd2;
    #1;
    check("flush_x1_qj", ID_qj, 32'd0);
    check("flush_x1_vj", ID_vj, 32'h8);
    check("flush_x2_qk", ID_qk, 32'd0);
    check("flush_x2_vk", ID_vk, 32'd0);
    ID_rs1 = 5'd5; ID_rs2 = 5'd4;
    #1;
    check("flush_x5_qj", ID_qj, 32'd0);
    check("flush_x5_rf_id1", RF_id1, 32'd0);
    check("flush_x4_qk", ID_qk, 32'd0);
    check("stale_val_x4_vk", ID_vk, 32'hBB);

    // rdy low holds state.
    rdy = 1'b0;
    ID_inst_flag = 1'b1; ID_inst_rd = 5'd6; ID_inst_rob_id = 32'd30;
    ROB_cmt_rf_flag = 1'b1; ROB_cmt_rf_rd = 5'd7; ROB_cmt_rf_rob_id = 32'd3; ROB_cmt_rf_val = 32'd1;
    tick();
    idle();
    rdy = 1'b1;
    ID_rs1 = 5'd6; ID_rs2 = 5'd7;
    #1;
    check("hold_x6_qj", ID_qj, 32'd0);
    check("hold_x6_rf_id1", RF_id1, 32'd0);
    check("hold_x7_vk", ID_vk, 32'd0);

    // Writes to x0 are dropped.
    ROB_cmt_rf_flag = 1'b1; ROB_cmt_rf_rd = 5'd0; ROB_cmt_rf_rob_id = 32'd5; ROB_cmt_rf_val = 32'hFF;
    ID_inst_flag = 1'b1; ID_inst_rd = 5'd0; ID_inst_rob_id = 32'd9;
    tick();
    idle();
    ID_rs1 = 5'd0; ID_rs2 = 5'd0;
    #1;
    check("x0_vj", ID_vj, 32'd0);
    check("x0_qj", ID_qj, 32'd0);
    check("x0_rf_id1", RF_id1, 32'd0);

    // Randomized traffic over a small register window to force collisions.
    for (int n = 0; n < 400; n++) begin
      rst               = ($urandom_range(0, 99) != 0);
      rdy               = ($urandom_range(0, 7) != 0);
      jump_wrong_flag   = ($urandom_range(0, 15) == 0);
      ID_inst_flag      = $urandom_range(0, 1) == 1;
      ID_inst_rd        = 5'($urandom_range(0, 7));
      ID_inst_rob_id    = $urandom_range(1, 15);
      ROB_cmt_rf_flag   = $urandom_range(0, 1) == 1;
      ROB_cmt_rf_rd     = 5'($urandom_range(0, 7));
      ROB_cmt_rf_rob_id = ($urandom_range(0, 1) == 1 && mtag[ROB_cmt_rf_rd] != 32'd0)
                          ? mtag[ROB_cmt_rf_rd] : $urandom_range(1, 15);
      ROB_cmt_rf_val    = $urandom;
      ID_rs1            = 5'($urandom_range(0, 7));
      ID_rs2            = 5'($urandom_range(0, 7));
      RF_id1_ready      = $urandom_range(0, 1) == 1;
      RF_id2_ready      = $urandom_range(0, 1) == 1;
      RF_id1_val        = $urandom;
      RF_id2_val        = $urandom;
      #1;
      model_read(ID_rs1, RF_id1_ready, RF_id1_val, eq, ev, eid);
      check("rand_qj", ID_qj, eq);
      check("rand_vj", ID_vj, ev);
      check("rand_rf_id1", RF_id1, eid);
      model_read(ID_rs2, RF_id2_ready, RF_id2_val, eq, ev, eid);
      check("rand_qk", ID_qk, eq);
      check("rand_vk", ID_vk, ev);
      check("rand_rf_id2", RF_id2, eid);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
